div_unit: RTL and testbench

Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage. It is the upstream source of the execute-stage stall request seen by the pipeline controller. The controller's flush output drives `annul_i` to cancel an in-flight division. The 64-bit `{remainder, quotient}` result is written to HI/LO by the execute stage.

---
 rtl/div_unit.sv | 185 ++++++++++++++++++
 tb/tb_div_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit radix-2 restoring divider (DIV / DIVU)
//
// This divider sits in the execute stage. While a division is running it
// requests a pipeline stall. The pipeline controller's flush cancels it
// through annul_i. The 64-bit result is {remainder, quotient}, and the
// execute stage writes it to HI/LO.
//
// Ports:
//   clk           in   1  pipeline clock, rising edge
//   rst           in   1  asynchronous active-low reset
//   signed_div_i  in   1  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     in  32  dividend, sampled when the division starts
//   opdata2_i     in  32  divisor, sampled when the division starts
//   start_i       in   1  request, held high until the result is consumed
//   annul_i       in   1  cancel an in-flight division (highest priority)
//   result_o      out 64  {remainder, quotient}, registered
//   ready_o       out  1  result valid, registered
//   stallreq_o    out  1  combinational stall request
//
// Configuration macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor takes a 2-cycle shortcut and returns 64'h0
//   undefined : a zero divisor runs the full iteration and returns the raw
//               algorithm output after sign fixup
// ---------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
`ifdef DIV_ZERO_DETECT_EN
    DIV_BY_ZERO = 2'd1,
`endif
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  div_state_t  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;       // upper partial remainder
  logic [31:0] r_quo;       // dividend bits shifting out, quotient bits shifting in
  logic [31:0] r_divisor;
  logic        r_neg_quo;
  logic        r_neg_rem;
  logic [63:0] r_result;
  logic        r_ready;

  div_state_t  w_state_next;
  logic [5:0]  w_cnt_next;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_divisor_next;
  logic        w_neg_quo_next;
  logic        w_neg_rem_next;
  logic [63:0] w_result_next;
  logic        w_ready_next;

  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_partial;
  logic        w_fits;
  logic [31:0] w_diff;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Operand magnitudes. The iteration always works on unsigned values.
  assign w_mag1 = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

  // Restoring step. Shift the next dividend bit into the 33-bit partial
  // remainder, then trial-subtract the divisor. When the trial is
  // non-negative, the true difference fits in 32 bits. This also holds for a
  // zero divisor, where the low 32 bits are exactly what should be kept.
  assign w_partial = {r_rem, r_quo[31]};
  assign w_fits    = (w_partial >= {1'b0, r_divisor});
  assign w_diff    = w_partial[31:0] - r_divisor;

  assign w_quo_fix = r_neg_quo ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_neg_rem ? (32'd0 - r_rem) : r_rem;

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready & ~annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= 6'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rem     <= w_rem_next;
      r_quo     <= w_quo_next;
      r_divisor <= w_divisor_next;
      r_neg_quo <= w_neg_quo_next;
      r_neg_rem <= w_neg_rem_next;
      r_result  <= w_result_next;
      r_ready   <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rem_next     = r_rem;
    w_quo_next     = r_quo;
    w_divisor_next = r_divisor;
    w_neg_quo_next = r_neg_quo;
    w_neg_rem_next = r_neg_rem;
    w_result_next  = r_result;
    w_ready_next   = r_ready;

    if (annul_i) begin
      // A flush wins over everything, including a start in DIV_FREE.
      w_state_next  = DIV_FREE;
      w_ready_next  = 1'b0;
      w_result_next = 64'd0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start_i) begin
            w_rem_next     = 32'd0;
            w_quo_next     = w_mag1;
            w_divisor_next = w_mag2;
            w_neg_quo_next = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            w_neg_rem_next = signed_div_i & opdata1_i[31];
            w_cnt_next     = 6'd0;
`ifdef DIV_ZERO_DETECT_EN
            w_state_next   = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
`else
            w_state_next   = DIV_ON;
`endif
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        DIV_BY_ZERO: begin
          w_state_next  = DIV_END;
          w_result_next = 64'd0;
          w_ready_next  = 1'b1;
        end
`endif
        DIV_ON: begin
          if (r_cnt != 6'd32) begin
            w_rem_next = w_fits ? w_diff : w_partial[31:0];
            w_quo_next = {r_quo[30:0], w_fits};
            w_cnt_next = r_cnt + 6'd1;
          end else begin
            w_result_next = {w_rem_fix, w_quo_fix};
            w_ready_next  = 1'b1;
            w_state_next  = DIV_END;
          end
        end
        DIV_END: begin
          // Hold the result until the execute stage drops its request.
          if (!start_i) begin
            w_state_next  = DIV_FREE;
            w_ready_next  = 1'b0;
            w_result_next = 64'd0;
          end
        end
        default: begin
          w_state_next = DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam logic [63:0] EXP_U5_0  = 64'h0;
  localparam logic [63:0] EXP_SM7_0 = 64'h0;
`else
  localparam logic [63:0] EXP_U5_0  = 64'h00000005_FFFFFFFF;
  localparam logic [63:0] EXP_SM7_0 = 64'hFFFFFFF9_00000001;
`endif

  typedef struct packed {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from the arithmetic definition: magnitudes, then
  // native / and %, then sign fixup.
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic        neg_a, neg_b;
    logic [31:0] ma, mb, q, r;
    neg_a = sd & a[31];
    neg_b = sd & b[31];
    ma = neg_a ? (32'd0 - a) : a;
    mb = neg_b ? (32'd0 - b) : b;
    if (mb == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
      return 64'h0;
`else
      q = 32'hFFFF_FFFF;
      r = ma;
`endif
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (neg_a != neg_b) q = 32'd0 - q;
    if (neg_a) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 2;
`endif
    return 34;
  endfunction

  // Starts a division in the current cycle (cycle 0) and holds start_i until
  // ready. It scrambles the operand inputs after cycle 0. The return values
  // are the ready cycle (-1 on timeout), the number of stall cycles, and the
  // stall value in the ready cycle.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int stalls,
                        output logic stall_done);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    stalls       = 0;
    res          = 64'h0;
    stall_done   = 1'bx;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (ready_o === 1'b1) begin
        lat        = c;
        res        = result_o;
        stall_done = stallreq_o;
        break;
      end
      if (stallreq_o === 1'b1) stalls++;
      tick();
      opdata1_i = $urandom;
      opdata2_i = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    tick(); tick();
    n_checks++;
    if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o);
    else n_pass++;
    n_checks++;
    if (result_o !== 64'h0) $display("FAIL reset_result: got %h expected 0", result_o);
    else n_pass++;
    n_checks++;
    if (stallreq_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stallreq_o);
    else n_pass++;
    rst = 1'b1;
    tick();
    $display("reset: ready=%b result=%h", ready_o, result_o);
  endtask

  task automatic test_directed();
    vec_t        v [8];
    logic [63:0] res;
    int          lat, stalls, exp_lat;
    logic        sdone;
    v[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
    v[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
    v[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
    v[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
    v[4] = '{1'b0, 32'd5,          32'd0,          EXP_U5_0};
    v[5] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          EXP_SM7_0};
    v[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
    v[7] = '{1'b0, 32'd7,          32'hFFFF_FFFF,  64'h00000007_00000000};
    for (int i = 0; i < 8; i++) begin
      exp_lat = ref_lat(v[i].b);
      do_div(v[i].sd, v[i].a, v[i].b, res, lat, stalls, sdone);
      $display("directed %0d: sd=%b a=%h b=%h result=%h lat=%0d", i, v[i].sd, v[i].a, v[i].b, res, lat);
      n_checks++;
      if (res !== v[i].exp) $display("FAIL dir_result[%0d]: got %h expected %h", i, res, v[i].exp);
      else n_pass++;
      n_checks++;
      if (lat !== exp_lat) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
      else n_pass++;
      n_checks++;
      if (stalls !== exp_lat) $display("FAIL dir_stall_cycles[%0d]: got %0d expected %0d", i, stalls, exp_lat);
      else n_pass++;
      n_checks++;
      if (sdone !== 1'b0) $display("FAIL dir_stall_at_ready[%0d]: got %b expected 0", i, sdone);
      else n_pass++;
      start_i = 1'b0;
      tick(); #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0)
        $display("FAIL dir_exit[%0d]: got ready=%b result=%h expected ready=0 result=0", i, ready_o, result_o);
      else n_pass++;
    end
  endtask

  // Random divisions issued at the earliest legal cycle after each other.
  task automatic test_random_back_to_back();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    logic        sd, sdone;
    int          lat, stalls;
    for (int i = 0; i < 24; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp = ref_div(sd, a, b);
      do_div(sd, a, b, res, lat, stalls, sdone);
      $display("random %0d: sd=%b a=%h b=%h result=%h lat=%0d", i, sd, a, b, res, lat);
      n_checks++;
      if (res !== exp) $display("FAIL rnd_result[%0d]: got %h expected %h", i, res, exp);
      else n_pass++;
      n_checks++;
      if (lat !== ref_lat(b)) $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, ref_lat(b));
      else n_pass++;
      start_i = 1'b0;
      tick(); #1;
      n_checks++;
      if (ready_o !== 1'b0) $display("FAIL rnd_exit[%0d]: got ready=%b expected 0", i, ready_o);
      else n_pass++;
    end
  endtask

  task automatic test_start_drop();
    logic [63:0] res;
    int          lat;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd9; start_i = 1'b1;
    lat = -1; res = 64'h0;
    for (int c = 0; c < 80; c++) begin
      if (c == 5) start_i = 1'b0;
      #1;
      if (c == 5) begin
        n_checks++;
        if (stallreq_o !== 1'b0) $display("FAIL drop_stall: got %b expected 0", stallreq_o);
        else n_pass++;
      end
      if (ready_o === 1'b1) begin
        lat = c;
        res = result_o;
        break;
      end
      tick();
    end
    $display("start_drop: result=%h lat=%0d", res, lat);
    n_checks++;
    if (lat !== 34) $display("FAIL drop_latency: got %0d expected 34", lat);
    else n_pass++;
    n_checks++;
    if (res !== 64'h00000001_0000006F) $display("FAIL drop_result: got %h expected 000000010000006f", res);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (ready_o !== 1'b0) $display("FAIL drop_exit: got ready=%b expected 0", ready_o);
    else n_pass++;
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int          lat, stalls;
    logic        sdone;
    // Annul in cycle 10 of a running division, then restart in cycle 12.
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) tick();
    annul_i = 1'b1;
    #1;
    n_checks++;
    if (stallreq_o !== 1'b0) $display("FAIL annul_stall: got %b expected 0", stallreq_o);
    else n_pass++;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL annul_clear: got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    else n_pass++;
    tick();
    do_div(1'b0, 32'd9, 32'd3, res, lat, stalls, sdone);
    $display("annul restart: result=%h lat=%0d", res, lat);
    n_checks++;
    if (lat !== 34) $display("FAIL annul_restart_latency: got %0d expected 34", lat);
    else n_pass++;
    n_checks++;
    if (res !== 64'h00000000_00000003) $display("FAIL annul_restart_result: got %h expected 0000000000000003", res);
    else n_pass++;
    // Annul while a finished result is held in DIV_END.
    tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL annul_end: got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    else n_pass++;
    tick();
    // Annul together with start in DIV_FREE must not latch anything.
    signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    do_div(1'b0, 32'd77, 32'd5, res, lat, stalls, sdone);
    $display("annul+start: result=%h lat=%0d", res, lat);
    n_checks++;
    if (lat !== 34) $display("FAIL annul_start_latency: got %0d expected 34", lat);
    else n_pass++;
    n_checks++;
    if (res !== 64'h00000002_0000000F) $display("FAIL annul_start_result: got %h expected 000000020000000f", res);
    else n_pass++;
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat, stalls;
    logic        sdone;
    signed_div_i = 1'b0; opdata1_i = 32'd123456; opdata2_i = 32'd789; start_i = 1'b1;
    repeat (20) tick();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL arst_mid: got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    else n_pass++;
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, stalls, sdone);
    $display("after reset: result=%h lat=%0d", res, lat);
    n_checks++;
    if (res !== 64'h00000000_80000000) $display("FAIL arst_div_result: got %h expected 0000000080000000", res);
    else n_pass++;
    n_checks++;
    if (lat !== 34) $display("FAIL arst_div_latency: got %0d expected 34", lat);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h00000000_80000000)
      $display("FAIL end_hold: got ready=%b result=%h expected ready=1 result=0000000080000000", ready_o, result_o);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL arst_end: got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    else n_pass++;
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_start_drop();
    test_annul();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
